axi4_sram_slave: RTL and testbench
==================================

// Module: axi4_sram_slave
// PURPOSE: AXI4 responder fronting a word-addressed on-chip SRAM. Target for the LSU/IFU AXI4 masters in sim and small SoC configs.
//   One transaction at a time; INCR/FIXED bursts (awlen/arlen 0..255); IDs echoed; full word returned (master aligns).
// PARAMETERS:
//   BASE_ADDR  32'h8000_0000  byte base of the window
//   DEPTH      16384          SRAM words (32-bit); window = DEPTH*4 bytes
//   RD_LAT     2              wait cycles before first R beat / B (only with AXI_SLV_LATENCY_EN)
// PORTS:
//   clk            in   1   clock
//   rst_n          in   1   reset, asynchronous, active-low
//   s_axi_awaddr   in   32  write byte address
//   s_axi_awvalid  in   1   AW valid
//   s_axi_awready  out  1   AW ready
//   s_axi_awid     in   4   write ID
//   s_axi_awlen    in   8   write beats-1
//   s_axi_awburst  in   2   00 FIXED, 01 INCR, else error
//   s_axi_wdata    in   32  write data
//   s_axi_wstrb    in   4   byte strobes
//   s_axi_wvalid   in   1   W valid
//   s_axi_wready   out  1   W ready
//   s_axi_bid      out  4   = latched awid
//   s_axi_bresp    out  2   OKAY/SLVERR/DECERR
//   s_axi_bvalid   out  1   B valid
//   s_axi_bready   in   1   B ready
//   s_axi_araddr   in   32  read byte address
//   s_axi_arvalid  in   1   AR valid
//   s_axi_arready  out  1   AR ready
//   s_axi_arid     in   4   read ID
//   s_axi_arlen    in   8   read beats-1
//   s_axi_arburst  in   2   as awburst
//   s_axi_rid      out  4   = latched arid
//   s_axi_rdata    out  32  read data, full word
//   s_axi_rresp    out  2   per-beat response
//   s_axi_rlast    out  1   final beat
//   s_axi_rvalid   out  1   R valid
//   s_axi_rready   in   1   R ready
// BEHAVIOUR:
// - Reset: all valid/ready outputs 0; rdata/rresp/bresp/rid/bid/rlast 0; FSM->IDLE. SRAM contents not reset; reset mid-burst aborts silently.
// - FSM: IDLE -> (AW) WR_DATA -> [WR_WAIT] -> WR_RESP -> IDLE; IDLE -> (AR) [RD_WAIT] -> RD_DATA -> IDLE.
// - IDLE: awready=arready=1 combinationally; AW and AR same cycle -> AW wins (store-before-load order), arready=0 that cycle.
// - Address/len/burst/id latched at handshake. wready=1 only in WR_DATA, so W waits for AW; master may present both together.
// - W beat on wvalid&wready: bytes with wstrb=1 written to mem[(addr-BASE)>>2]; beat counter counts to awlen; wlast not consulted.
// - INCR: addr+=4 per beat; FIXED: addr held; 4KB boundary not checked.
// - Error (sticky per burst): burst 2'b1x -> SLVERR, no writes, reads return 0; word index >= DEPTH -> DECERR for that beat, write dropped, rdata 0.
// - WR_RESP: bvalid=1 next cycle after last W beat; held, bid/bresp stable, until bready; then IDLE; awready reasserted that cycle.
// - RD_DATA: registered SRAM read, first rvalid 1 cycle after AR handshake; rdata/rresp/rlast held while rvalid&!rready.
//   Next beat presented the cycle after acceptance (1 beat/2 cycles max); rlast=1 on beat arlen; returns to IDLE after it is accepted.
// - Single-beat (len 0): rlast=1 on sole beat; B after single W.
// CONFIGURATION:
// - AXI_SLV_LATENCY_EN defined: WR_WAIT/RD_WAIT insert RD_LAT idle cycles before B / first R beat. Undefined: both states bypassed, no wait cycles.
// STRUCTURE:
// - Package axi4_pkg: RESP_OKAY/SLVERR/DECERR, BURST_FIXED/INCR, ID_W=4, state enum.
// - Sub-module axi_sram_1rw (DEPTH x 32, byte-enable write, 1-cycle registered read).
// TESTING:
// - Write 0xDEADBEEF @0x8000_0010 id=1 strb=F, then read len0 -> bid=1 bresp=0, rdata=0xDEADBEEF, rlast=1, rid=1.
// - Strb=4'b0010 data 0x0000_AB00 over 0xDEADBEEF -> read returns 0xDEADABEF.
// - INCR read arlen=3 @0x8000_0000 after writing 0..3 -> four beats 0,1,2,3, rlast only on 4th; rready toggled 1/0 -> data held stable.
// - AW and AR asserted same cycle -> AW accepted, arready=0; AR accepted after B handshake.
// - Read @BASE+DEPTH*4 -> rresp=2'b11, rdata=0; arburst=2'b10 -> SLVERR every beat, memory unchanged.
// - rst_n low mid-burst (beat 2 of 4) -> rvalid=0 immediately, IDLE, next AR serviced normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state type and the per-beat response rule
// used by the SRAM-backed AXI4 responder.
package axi4_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_DATA = 3'd5
  } state_t;

  // A bad burst type poisons every beat; otherwise a beat outside the window
  // (offset wraps huge when below the base) decodes to nothing.
  function automatic logic [1:0] beat_resp(input logic        burst_err,
                                           input logic [31:0] offset,
                                           input logic [32:0] window_bytes);
    if (burst_err)
      return RESP_SLVERR;
    else if ({1'b0, offset} >= window_bytes)
      return RESP_DECERR;
    else
      return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_sram_1rw.sv
// Single-port DEPTH x 32 SRAM: byte-enable write, one-cycle registered read.
// Read data holds until the next read access.
module axi_sram_1rw #(
  parameter int DEPTH = 16384,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 responder over a word-addressed SRAM, one transaction at a time.
// Optional wait states before B / first R beat: define AXI_SLV_LATENCY_EN.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 16384,
  parameter int          RD_LAT    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     s_axi_awaddr,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [ID_W-1:0] s_axi_awid,
  input  logic [7:0]      s_axi_awlen,
  input  logic [1:0]      s_axi_awburst,
  input  logic [31:0]     s_axi_wdata,
  input  logic [3:0]      s_axi_wstrb,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [ID_W-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [31:0]     s_axi_araddr,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  input  logic [ID_W-1:0] s_axi_arid,
  input  logic [7:0]      s_axi_arlen,
  input  logic [1:0]      s_axi_arburst,
  output logic [ID_W-1:0] s_axi_rid,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready
);

  // Handshakes: a transfer happens on any rising clk edge where valid and
  // ready are both high; valid never waits on ready, and R/B payloads stay
  // stable while valid is high and ready is low.

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;
  localparam logic [7:0]  WAIT_LAST = 8'(RD_LAT - 1);
`ifdef AXI_SLV_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  logic            live_q;
  logic [31:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [7:0]      wait_q;
  logic [ID_W-1:0] id_q;
  logic            berr_q;
  logic            fixed_q;
  logic [1:0]      wresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic            rlast_q;

  logic            aw_hs, ar_hs, w_hs, rd_acc, issue;
  logic            mem_en, mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]     mem_rdata;
  logic [31:0]     cur_off, ar_off, addr_next;
  logic [1:0]      cur_resp, issue_resp;
  logic            issue_last;

  assign cur_off   = addr_q - BASE_ADDR;
  assign ar_off    = s_axi_araddr - BASE_ADDR;
  assign cur_resp  = beat_resp(berr_q, cur_off, WIN_BYTES);
  assign addr_next = fixed_q ? addr_q : addr_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    aw_hs         = 1'b0;
    ar_hs         = 1'b0;
    w_hs          = 1'b0;
    rd_acc        = 1'b0;
    issue         = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_idx       = cur_off[IDX_W+1:2];
    issue_resp    = cur_resp;
    issue_last    = (cnt_q == len_q);
    case (state_q)
      ST_IDLE: begin
        s_axi_awready = live_q;
        s_axi_arready = live_q & ~s_axi_awvalid;
        if (live_q && s_axi_awvalid) begin
          aw_hs   = 1'b1;
          state_d = ST_WR_DATA;
        end else if (live_q && s_axi_arvalid) begin
          ar_hs = 1'b1;
          if (LAT_EN) begin
            state_d = ST_RD_WAIT;
          end else begin
            // First beat is read straight off the AR channel.
            state_d    = ST_RD_DATA;
            issue      = 1'b1;
            mem_en     = 1'b1;
            mem_idx    = ar_off[IDX_W+1:2];
            issue_resp = beat_resp(s_axi_arburst[1], ar_off, WIN_BYTES);
            issue_last = (s_axi_arlen == 8'd0);
          end
        end
      end
      ST_WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          w_hs   = 1'b1;
          mem_en = (cur_resp == RESP_OKAY);
          mem_we = 1'b1;
          if (cnt_q == len_q) state_d = LAT_EN ? ST_WR_WAIT : ST_WR_RESP;
        end
      end
      ST_WR_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (s_axi_bready) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          issue   = 1'b1;
          mem_en  = 1'b1;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rvalid_q) begin
          if (s_axi_rready) begin
            rd_acc = 1'b1;
            if (rlast_q) state_d = ST_IDLE;
          end
        end else begin
          // Bubble cycle after each accepted beat fetches the next word.
          issue  = 1'b1;
          mem_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      live_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      id_q     <= '0;
      berr_q   <= 1'b0;
      fixed_q  <= 1'b0;
      wresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (aw_hs) begin
        addr_q  <= s_axi_awaddr;
        len_q   <= s_axi_awlen;
        id_q    <= s_axi_awid;
        berr_q  <= s_axi_awburst[1];
        fixed_q <= (s_axi_awburst == BURST_FIXED);
        cnt_q   <= '0;
        wait_q  <= '0;
        wresp_q <= RESP_OKAY;
      end
      if (ar_hs) begin
        addr_q  <= s_axi_araddr;
        len_q   <= s_axi_arlen;
        id_q    <= s_axi_arid;
        berr_q  <= s_axi_arburst[1];
        fixed_q <= (s_axi_arburst == BURST_FIXED);
        cnt_q   <= '0;
        wait_q  <= '0;
      end
      if (w_hs) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= addr_next;
        if (wresp_q == RESP_OKAY) wresp_q <= cur_resp;
      end
      if (state_q == ST_WR_WAIT || state_q == ST_RD_WAIT) wait_q <= wait_q + 8'd1;
      if (issue) begin
        rvalid_q <= 1'b1;
        rresp_q  <= issue_resp;
        rlast_q  <= issue_last;
      end
      if (rd_acc) begin
        rvalid_q <= 1'b0;
        cnt_q    <= cnt_q + 8'd1;
        addr_q   <= addr_next;
      end
    end
  end

  axi_sram_1rw #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .be    (s_axi_wstrb),
    .idx   (mem_idx),
    .wdata (s_axi_wdata),
    .rdata (mem_rdata)
  );

  assign s_axi_bvalid = (state_q == ST_WR_RESP);
  assign s_axi_bid    = id_q;
  assign s_axi_bresp  = wresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rid    = id_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rdata  = (rvalid_q && rresp_q == RESP_OKAY) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: drivers push expected R/B responses
// into queues, a negedge monitor pops and compares on each handshake.
module tb_axi4_sram_slave;

  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = 2'b01;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = 2'b01;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;

  int checks = 0;
  int fails  = 0;

  // {id, resp, last, data} and {id, resp}
  logic [38:0] exp_r[$];
  logic [5:0]  exp_b[$];

  axi4_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
  endtask

  // Monitor / scoreboard
  logic        r_hold = 1'b0;
  logic [38:0] r_held;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_hold = 1'b0;
    end else begin
      if (rvalid) begin
        if (r_hold) check("r_hold_stable", {rid, rresp, rlast, rdata}, r_held);
        if (rready) begin
          r_hold = 1'b0;
          if (exp_r.size() == 0) begin
            checks++; fails++;
            $display("FAIL r_unexpected: got 0x%0h expected no beat", {rid, rresp, rlast, rdata});
          end else begin
            check("r_beat", {rid, rresp, rlast, rdata}, exp_r.pop_front());
          end
        end else begin
          r_hold = 1'b1;
          r_held = {rid, rresp, rlast, rdata};
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++; fails++;
          $display("FAIL b_unexpected: got 0x%0h expected no response", {bid, bresp});
        end else begin
          check("b_resp", {bid, bresp}, exp_b.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("aw_wait");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] strb);
    int n = 0;
    wdata = d; wstrb = strb; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("w_wait");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    araddr = a; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("ar_wait");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic write1(input logic [31:0] a, input logic [3:0] id, input logic [1:0] burst,
                        input logic [31:0] d, input logic [3:0] strb, input logic [1:0] resp);
    exp_b.push_back({id, resp});
    aw_send(a, id, 8'd0, burst);
    w_send(d, strb);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < BUDGET) begin
      @(posedge clk); n++;
    end
    if (n >= BUDGET) timeout("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid();
    int n = 0;
    @(negedge clk);
    while (!rvalid && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("rvalid_wait");
  endtask

  initial begin
    // Reset state
    #12;
    @(negedge clk);
    check("rst_ready", {awready, arready, wready}, 3'b000);
    check("rst_valid", {rvalid, bvalid, rlast}, 3'b000);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp_ids", {rresp, bresp, rid, bid}, 12'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full word write then single-beat read
    write1(32'h8000_0010, 4'd1, 2'b01, 32'hDEAD_BEEF, 4'hF, 2'b00);
    exp_r.push_back({4'd1, 2'b00, 1'b1, 32'hDEAD_BEEF});
    ar_send(32'h8000_0010, 4'd1, 8'd0, 2'b01);
    wait_drain();

    // Byte-strobe merge
    write1(32'h8000_0010, 4'd2, 2'b01, 32'h0000_AB00, 4'b0010, 2'b00);
    exp_r.push_back({4'd3, 2'b00, 1'b1, 32'hDEAD_ABEF});
    ar_send(32'h8000_0010, 4'd3, 8'd0, 2'b01);
    wait_drain();

    // INCR write of 0..3, INCR read back with rready stalls
    exp_b.push_back({4'd4, 2'b00});
    aw_send(32'h8000_0000, 4'd4, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'(i), 4'hF);
    wait_drain();
    for (int i = 0; i < 4; i++) exp_r.push_back({4'd5, 2'b00, (i == 3), 32'(i)});
    rready = 1'b0;
    ar_send(32'h8000_0000, 4'd5, 8'd3, 2'b01);
    for (int k = 0; k < 60 && exp_r.size() != 0; k++) begin
      rready = (k % 3 == 2);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_drain();

    // AW and AR together: AW wins, AR waits for the B handshake
    exp_b.push_back({4'd6, 2'b00});
    exp_r.push_back({4'd7, 2'b00, 1'b1, 32'h0000_0055});
    awaddr = 32'h8000_0020; awid = 4'd6; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    araddr = 32'h8000_0020; arid = 4'd7; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("coll_awready", awready, 1'b1);
    check("coll_arready", arready, 1'b0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_send(32'h0000_0055, 4'hF);
    begin
      int n = 0;
      @(negedge clk);
      while (!arready && n < BUDGET) begin @(negedge clk); n++; end
      if (n >= BUDGET) timeout("coll_ar_wait");
      check("ar_after_b", exp_b.size(), 0);
      @(posedge clk); #1;
      arvalid = 1'b0;
    end
    wait_drain();

    // Out-of-window accesses
    exp_r.push_back({4'd8, 2'b11, 1'b1, 32'd0});
    ar_send(32'h8001_0000, 4'd8, 8'd0, 2'b01);
    wait_drain();
    write1(32'h8001_0000, 4'd8, 2'b01, 32'h1234_5678, 4'hF, 2'b11);
    wait_drain();

    // Reserved burst types
    exp_r.push_back({4'd9, 2'b10, 1'b0, 32'd0});
    exp_r.push_back({4'd9, 2'b10, 1'b1, 32'd0});
    ar_send(32'h8000_0000, 4'd9, 8'd1, 2'b10);
    wait_drain();
    write1(32'h8000_0000, 4'd9, 2'b11, 32'hFFFF_FFFF, 4'hF, 2'b10);
    exp_r.push_back({4'd9, 2'b00, 1'b1, 32'd0});
    ar_send(32'h8000_0000, 4'd9, 8'd0, 2'b01);
    wait_drain();

    // Reset while beat 2 of 4 is pending
    rready = 1'b0;
    exp_r.push_back({4'd10, 2'b00, 1'b0, 32'd0});
    ar_send(32'h8000_0000, 4'd10, 8'd3, 2'b01);
    wait_rvalid();
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    wait_rvalid();
    check("mid_beat2_data", rdata, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_ready", {arready, awready}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rready = 1'b1;
    exp_r.push_back({4'd11, 2'b00, 1'b1, 32'd1});
    ar_send(32'h8000_0004, 4'd11, 8'd0, 2'b01);
    wait_drain();

    check("queues_empty", exp_r.size() + exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
